instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 32'd0, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter IMEM_TIMEOUT, default 8, meaning the maximum number of consecutive busy-wait cycles before the fetch is aborted.
REQ-003 The block SHALL have port CLK  input  1  system clock; all state SHALL change on the rising edge.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port IMEM_READ  output  1  instruction-memory read request.
REQ-006 The block SHALL have port IMEM_ADDR  output  32  fetch address, always equal to PC.
REQ-007 The block SHALL have port IMEM_BUSYWAIT  input  1  high while instruction memory is not ready.
REQ-008 The block SHALL have port INSTRUCTION  input  32  instruction word, valid when IMEM_BUSYWAIT=0.
REQ-009 The block SHALL have port WRITEENABLE  output  1  register-file write strobe.
REQ-010 The block SHALL have port ALUOP  output  3  ALU operation (000 fwd, 001 add, 010 and, 011 or).
REQ-011 The block SHALL have port ALUSRC  output  1  operand select (1 register, 0 immediate).
REQ-012 The block SHALL have port NEMUX  output  1  negate second operand.
REQ-013 The block SHALL have ports DEST, SRC1 and SRC2  output  3 each  register addresses.
REQ-014 The block SHALL have port IMMEDIATE  output  8  immediate field.
REQ-015 The block SHALL have port PC  output  32  current program counter.
REQ-016 The block SHALL have port ILLEGAL  output  1  sticky illegal-opcode/fetch-timeout flag.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, DECODE, EXECUTE and WRITEBACK; all outputs SHALL be registered.
REQ-018 IDLE SHALL transition to FETCH on the first clock edge after RESET deasserts.
REQ-019 In FETCH, IMEM_READ SHALL be 1; while IMEM_BUSYWAIT=1 the FSM SHALL stay in FETCH and increment a wait counter.
REQ-020 On an edge in FETCH with IMEM_BUSYWAIT=0, the block SHALL latch INSTRUCTION into IR, clear the wait counter and go to DECODE; IMEM_READ SHALL drop in the next cycle.
REQ-021 If the wait counter reaches IMEM_TIMEOUT, the block SHALL set ILLEGAL, leave IR unchanged, and go to WRITEBACK with no write.
REQ-022 IR field mapping SHALL be: opcode = IR[31:24], DEST = IR[18:16], SRC1 = IR[10:8], SRC2 = IR[2:0], IMMEDIATE = IR[7:0].
REQ-023 In DECODE, the block SHALL register ALUOP/ALUSRC/NEMUX from the opcode: 00 add (001,1,0); 01 sub (001,1,1); 02 and (010,1,0); 03 or (011,1,0); 04 mov (000,1,0); 05 loadi (000,0,0).
REQ-024 An opcode greater than 05 SHALL set ILLEGAL and SHALL suppress WRITEENABLE for that instruction.
REQ-025 EXECUTE SHALL last exactly one cycle (ALU settle) and SHALL hold all control outputs.
REQ-026 WRITEBACK SHALL last exactly one cycle: WRITEENABLE=1 only for legal opcodes, PC <= PC+4 (mod 2^32), then the FSM SHALL return to FETCH.
REQ-027 WRITEENABLE SHALL be 0 in every state other than WRITEBACK.
REQ-028 With zero wait, an instruction SHALL take 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
REQ-029 PC wrap SHALL be 32'hFFFFFFFC -> 32'h00000000 with no flag.
REQ-030 ILLEGAL SHALL be sticky and SHALL clear only on reset; execution SHALL continue after it is set.

Reset
REQ-031 RESET=1 SHALL immediately force: state IDLE, PC=PC_RESET, IR=0, IMEM_READ=0, WRITEENABLE=0, ALUOP=000, ALUSRC=1, NEMUX=0, DEST/SRC1/SRC2=0, IMMEDIATE=0, ILLEGAL=0, wait counter=0.
REQ-032 A reset asserted mid-fetch or mid-WRITEBACK SHALL abort the operation with no write and no PC increment.

Structure
REQ-033 Opcode constants, ALUOP encodings, state encoding and IR field positions SHALL reside in a shared package, proc_pkg.
REQ-034 Opcode-to-control decoding SHALL be a combinational sub-module, op_decoder; the FSM, PC, IR and wait counter SHALL reside in instr_sequencer.

Verification
REQ-035 Reset, then LOADI 0x05020011 with zero wait -> DEST=2, IMMEDIATE=0x11, ALUSRC=0, WRITEENABLE high in cycle 4 only, PC 0->4.
REQ-036 SUB 0x01030102 -> ALUOP=001, NEMUX=1, SRC1=1, SRC2=2, DEST=3, one write strobe.
REQ-037 IMEM_BUSYWAIT high for 3 cycles -> FETCH held 4 cycles, IMEM_READ stable, instruction completes in 7 cycles.
REQ-038 Opcode 0x07 -> ILLEGAL=1, no WRITEENABLE, PC advances by 4; next legal instruction writes normally with ILLEGAL still 1.
REQ-039 IMEM_BUSYWAIT stuck high -> ILLEGAL after 8 wait cycles, no write, PC+4; PC_RESET=32'hFFFFFFFC -> PC wraps to 0.
REQ-040 RESET pulsed during EXECUTE -> outputs reset asynchronously, no write, PC=PC_RESET.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the instruction sequencer.
//   - state_t      : sequencer FSM state encoding
//   - OP_*         : opcode values (IR[31:24])
//   - ALU_*        : ALUOP encodings driven to the datapath
//   - *_MSB/*_LSB  : instruction-register field positions
//   - ctrl_t       : decoded control bundle produced by op_decoder
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_t;

    localparam logic [7:0] OP_ADD   = 8'h00;
    localparam logic [7:0] OP_SUB   = 8'h01;
    localparam logic [7:0] OP_AND   = 8'h02;
    localparam logic [7:0] OP_OR    = 8'h03;
    localparam logic [7:0] OP_MOV   = 8'h04;
    localparam logic [7:0] OP_LOADI = 8'h05;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 24;
    localparam int DEST_MSB   = 18;
    localparam int DEST_LSB   = 16;
    localparam int SRC1_MSB   = 10;
    localparam int SRC1_LSB   = 8;
    localparam int SRC2_MSB   = 2;
    localparam int SRC2_LSB   = 0;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    typedef struct packed {
        logic [2:0] aluop;
        logic       alusrc;   // 1 = register operand, 0 = immediate
        logic       nemux;    // negate second operand
        logic       legal;
    } ctrl_t;

    function automatic logic [7:0] ir_opcode(input logic [31:0] ir);
        return ir[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/op_decoder.sv
// op_decoder: purely combinational opcode-to-control translation.
//   opcode : IR[31:24]
//   ctrl   : ALUOP / ALUSRC / NEMUX plus a legal flag (0 for opcodes > 05)
module op_decoder
    import proc_pkg::*;
(
    input  logic [7:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl.aluop  = ALU_FWD;
        ctrl.alusrc = 1'b1;
        ctrl.nemux  = 1'b0;
        ctrl.legal  = 1'b1;
        case (opcode)
            OP_ADD:   ctrl.aluop = ALU_ADD;
            OP_SUB: begin
                ctrl.aluop = ALU_ADD;
                ctrl.nemux = 1'b1;
            end
            OP_AND:   ctrl.aluop = ALU_AND;
            OP_OR:    ctrl.aluop = ALU_OR;
            OP_MOV:   ctrl.aluop = ALU_FWD;
            OP_LOADI: ctrl.alusrc = 1'b0;
            default:  ctrl.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute/writeback sequencer.
//   CLK, RESET (async, active high)
//   IMEM_READ/IMEM_ADDR out, IMEM_BUSYWAIT/INSTRUCTION in : instruction fetch
//   WRITEENABLE, ALUOP, ALUSRC, NEMUX, DEST, SRC1, SRC2, IMMEDIATE : datapath control
//   PC : program counter, ILLEGAL : sticky illegal-opcode / fetch-timeout flag
// Every output comes straight from a flop.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter logic [31:0] PC_RESET     = 32'd0,
    parameter int          IMEM_TIMEOUT = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] INSTRUCTION,
    output logic        WRITEENABLE,
    output logic [2:0]  ALUOP,
    output logic        ALUSRC,
    output logic        NEMUX,
    output logic [2:0]  DEST,
    output logic [2:0]  SRC1,
    output logic [2:0]  SRC2,
    output logic [7:0]  IMMEDIATE,
    output logic [31:0] PC,
    output logic        ILLEGAL
);

    localparam int WAIT_W = $clog2(IMEM_TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
    logic                imem_read_q, imem_read_d;
    logic                we_q, we_d;
    logic                wb_en_q, wb_en_d;   // current instruction may write back
    logic [2:0]          aluop_q, aluop_d;
    logic                alusrc_q, alusrc_d;
    logic                nemux_q, nemux_d;
    logic [2:0]          dest_q, dest_d;
    logic [2:0]          src1_q, src1_d;
    logic [2:0]          src2_q, src2_d;
    logic [7:0]          imm_q, imm_d;
    logic                illegal_q, illegal_d;

    logic [7:0]          opcode;
    ctrl_t               dec_ctrl;
    logic                ir_unused;

    assign opcode    = ir_opcode(ir_q);
    // IR bits that no field maps to
    assign ir_unused = ^{ir_q[23:19], ir_q[15:11]};

    op_decoder u_op_decoder (
        .opcode (opcode),
        .ctrl   (dec_ctrl)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        wait_d      = wait_q;
        imem_read_d = imem_read_q;
        we_d        = 1'b0;
        wb_en_d     = wb_en_q;
        aluop_d     = aluop_q;
        alusrc_d    = alusrc_q;
        nemux_d     = nemux_q;
        dest_d      = dest_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        imm_d       = imm_q;
        illegal_d   = illegal_q;
        wait_inc    = wait_q + WAIT_W'(1);

        case (state_q)
            ST_IDLE: begin
                state_d     = ST_FETCH;
                imem_read_d = 1'b1;
            end
            ST_FETCH: begin
                if (!IMEM_BUSYWAIT) begin
                    ir_d        = INSTRUCTION;
                    wait_d      = '0;
                    imem_read_d = 1'b0;
                    state_d     = ST_DECODE;
                end else if (wait_inc == WAIT_W'(IMEM_TIMEOUT)) begin
                    // Abort the fetch: IR keeps its old contents, no write.
                    illegal_d   = 1'b1;
                    wait_d      = '0;
                    wb_en_d     = 1'b0;
                    imem_read_d = 1'b0;
                    state_d     = ST_WRITEBACK;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_DECODE: begin
                aluop_d  = dec_ctrl.aluop;
                alusrc_d = dec_ctrl.alusrc;
                nemux_d  = dec_ctrl.nemux;
                dest_d   = ir_q[DEST_MSB:DEST_LSB];
                src1_d   = ir_q[SRC1_MSB:SRC1_LSB];
                src2_d   = ir_q[SRC2_MSB:SRC2_LSB];
                imm_d    = ir_q[IMM_MSB:IMM_LSB];
                wb_en_d  = dec_ctrl.legal;
                if (!dec_ctrl.legal) begin
                    illegal_d = 1'b1;
                end
                state_d  = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                // Strobe is registered, so it is high exactly during WRITEBACK.
                we_d    = wb_en_q;
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                pc_d        = pc_q + 32'd4;
                imem_read_d = 1'b1;
                state_d     = ST_FETCH;
            end
            default: begin
                imem_read_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            pc_q        <= PC_RESET;
            ir_q        <= '0;
            wait_q      <= '0;
            imem_read_q <= 1'b0;
            we_q        <= 1'b0;
            wb_en_q     <= 1'b0;
            aluop_q     <= ALU_FWD;
            alusrc_q    <= 1'b1;
            nemux_q     <= 1'b0;
            dest_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            wait_q      <= wait_d;
            imem_read_q <= imem_read_d;
            we_q        <= we_d;
            wb_en_q     <= wb_en_d;
            aluop_q     <= aluop_d;
            alusrc_q    <= alusrc_d;
            nemux_q     <= nemux_d;
            dest_q      <= dest_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            imm_q       <= imm_d;
            illegal_q   <= illegal_d;
        end
    end

    assign IMEM_READ   = imem_read_q;
    assign IMEM_ADDR   = pc_q;
    assign PC          = pc_q;
    assign WRITEENABLE = we_q;
    assign ALUOP       = aluop_q;
    assign ALUSRC      = alusrc_q;
    assign NEMUX       = nemux_q;
    assign DEST        = dest_q;
    assign SRC1        = src1_q;
    assign SRC2        = src2_q;
    assign IMMEDIATE   = imm_q;
    assign ILLEGAL     = illegal_q;

endmodule
